// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the MEM/WB register layout, writeback FSM states and
// architectural register-file dimensions.
package pipeline_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       mem_read_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_to_reg;
    } mem_wb_reg_struct;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATCHED = 2'd1,
        COMMIT  = 2'd2
    } wb_state_t;

    // Load results come from memory, everything else from the ALU.
    function automatic logic [XLEN-1:0] select_wb_data(input mem_wb_reg_struct entry);
        return entry.mem_to_reg ? entry.mem_read_data : entry.alu_result;
    endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port; x0 is hardwired to zero on both the write and read side.
module regfile
    import pipeline_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata
);

    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: latches one MEM/WB entry, optionally holds it, then commits
// it to the register file for one cycle with a read bypass during commit.
module writeback_unit
    import pipeline_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_wb_push_done,
    input  mem_wb_reg_struct      mem_wb_reg,
    input  logic                  wb_hold,
    output logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  wb_commit,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic [63:0]           retired_count,
    output logic                  protocol_err
);

    wb_state_t        state;
    mem_wb_reg_struct wb_buf;
    logic             commit_we;
    logic [XLEN-1:0]  rf_rdata1;
    logic [XLEN-1:0]  rf_rdata2;

    assign wb_valid = (state == IDLE) && !wb_hold;

    // Commit outputs are loaded on the LATCHED->COMMIT edge so they are
    // registered and aligned with the COMMIT state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wb_buf        <= '0;
            wb_commit     <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            commit_we     <= 1'b0;
            retired_count <= '0;
            protocol_err  <= 1'b0;
        end else begin
            if (mem_wb_push_done && (state != IDLE)) begin
                protocol_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mem_wb_push_done) begin
                        wb_buf <= mem_wb_reg;
                        state  <= LATCHED;
                    end
                end
                LATCHED: begin
                    if (!wb_hold) begin
                        state     <= COMMIT;
                        wb_commit <= 1'b1;
                        wb_rd     <= wb_buf.rd;
                        wb_data   <= select_wb_data(wb_buf);
                        commit_we <= wb_buf.reg_write && (wb_buf.rd != '0);
                    end
                end
                COMMIT: begin
                    state         <= IDLE;
                    wb_commit     <= 1'b0;
                    wb_rd         <= '0;
                    wb_data       <= '0;
                    commit_we     <= 1'b0;
                    retired_count <= retired_count + 64'd1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (commit_we),
        .waddr  (wb_rd),
        .wdata  (wb_data)
    );

    // commit_we is only ever set while committing, so it alone qualifies the bypass.
    always_comb begin
        rs1_data = rf_rdata1;
        rs2_data = rf_rdata2;
        if (commit_we && (rs1_addr == wb_rd)) begin
            rs1_data = wb_data;
        end
        if (commit_we && (rs2_addr == wb_rd)) begin
            rs2_data = wb_data;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed testbench for writeback_unit: stimulus queues expected commits,
// an independent monitor pops and compares them whenever wb_commit fires.
module tb_writeback_unit;
    import pipeline_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             mem_wb_push_done = 1'b0;
    mem_wb_reg_struct mem_wb_reg = '0;
    logic             wb_hold = 1'b0;
    logic             wb_valid;
    logic [4:0]       rs1_addr = '0;
    logic [4:0]       rs2_addr = '0;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic             wb_commit;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic [63:0]      retired_count;
    logic             protocol_err;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    writeback_unit dut (
        .clk              (clk),
        .reset            (reset),
        .mem_wb_push_done (mem_wb_push_done),
        .mem_wb_reg       (mem_wb_reg),
        .wb_hold          (wb_hold),
        .wb_valid         (wb_valid),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .wb_commit        (wb_commit),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .retired_count    (retired_count),
        .protocol_err     (protocol_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every commit pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset && wb_commit) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_commit: got rd %0d data 0x%0h, expected no commit", wb_rd, wb_data);
            end else begin
                e = sb.pop_front();
                check_output("commit_rd", 64'(wb_rd), 64'(e.rd));
                check_output("commit_data", 64'(wb_data), 64'(e.data));
                check_output("commit_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] rd,
                                  input logic rw, input logic m2r, input logic [31:0] exp_data,
                                  input int hold_cycles);
        @(negedge clk);
        mem_wb_reg = '{alu_result: alu, mem_read_data: mem, rd: rd, reg_write: rw, mem_to_reg: m2r};
        mem_wb_push_done = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{rd: rd, data: exp_data, cyc: cyc + 1 + hold_cycles});
        @(negedge clk);
        mem_wb_push_done = 1'b0;
        for (int i = 0; i < hold_cycles; i++) begin
            wb_hold = 1'b1;
            #1;
            check_output("hold_wb_valid", 64'(wb_valid), 64'd0);
            @(negedge clk);
        end
        wb_hold = 1'b0;
    endtask

    task automatic wait_commit();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_output("commit_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic read_reg(input string name, input logic [4:0] addr, input logic [31:0] exp);
        @(negedge clk);
        rs1_addr = addr;
        rs2_addr = addr;
        #1;
        check_output({name, "_rs1"}, 64'(rs1_data), 64'(exp));
        check_output({name, "_rs2"}, 64'(rs2_data), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_commit", 64'(wb_commit), 64'd0);
        check_output("rst_rd", 64'(wb_rd), 64'd0);
        check_output("rst_data", 64'(wb_data), 64'd0);
        check_output("rst_retired", retired_count, 64'd0);
        check_output("rst_perr", 64'(protocol_err), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("valid_after_release", 64'(wb_valid), 64'd1);
        wb_hold = 1'b1;
        #1;
        check_output("idle_hold_valid", 64'(wb_valid), 64'd0);
        wb_hold = 1'b0;

        // ALU result to x5
        apply_stimulus(32'h1234, 32'hFFFF_0000, 5'd5, 1'b1, 1'b0, 32'h1234, 0);
        wait_commit();
        read_reg("x5", 5'd5, 32'h1234);
        check_output("retired_1", retired_count, 64'd1);

        // Load to x0 commits but never writes
        apply_stimulus(32'h1111, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 0);
        wait_commit();
        read_reg("x0", 5'd0, 32'h0);
        check_output("retired_2", retired_count, 64'd2);

        // Held three cycles in LATCHED
        apply_stimulus(32'hA5, 32'h0, 5'd7, 1'b1, 1'b0, 32'hA5, 3);
        wait_commit();
        read_reg("x7", 5'd7, 32'hA5);
        check_output("retired_3", retired_count, 64'd3);

        // reg_write=0 retires without writing
        apply_stimulus(32'h9999, 32'h0, 5'd5, 1'b0, 1'b0, 32'h9999, 0);
        wait_commit();
        read_reg("x5_nowrite", 5'd5, 32'h1234);
        check_output("retired_4", retired_count, 64'd4);

        // Bypass during COMMIT of x9
        @(negedge clk);
        rs1_addr = 5'd9;
        rs2_addr = 5'd5;
        mem_wb_reg = '{alu_result: 32'h55, mem_read_data: 32'h66, rd: 5'd9, reg_write: 1'b1, mem_to_reg: 1'b0};
        mem_wb_push_done = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{rd: 5'd9, data: 32'h55, cyc: cyc + 1});
        check_output("x9_latched", 64'(rs1_data), 64'd0);
        @(negedge clk);
        mem_wb_push_done = 1'b0;
        @(posedge clk);
        #2;
        check_output("bypass_rs1", 64'(rs1_data), 64'h55);
        check_output("bypass_rs2_other", 64'(rs2_data), 64'h1234);
        wait_commit();
        read_reg("x9", 5'd9, 32'h55);

        // Second push while LATCHED is dropped and flagged
        check_output("perr_before", 64'(protocol_err), 64'd0);
        @(negedge clk);
        mem_wb_reg = '{alu_result: 32'h77, mem_read_data: 32'h0, rd: 5'd10, reg_write: 1'b1, mem_to_reg: 1'b0};
        mem_wb_push_done = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{rd: 5'd10, data: 32'h77, cyc: cyc + 1});
        @(negedge clk);
        mem_wb_reg = '{alu_result: 32'h88, mem_read_data: 32'h0, rd: 5'd11, reg_write: 1'b1, mem_to_reg: 1'b0};
        @(negedge clk);
        mem_wb_push_done = 1'b0;
        wait_commit();
        check_output("perr_set", 64'(protocol_err), 64'd1);
        read_reg("x10", 5'd10, 32'h77);
        read_reg("x11", 5'd11, 32'h0);
        check_output("retired_6", retired_count, 64'd6);
        apply_stimulus(32'h12, 32'h0, 5'd12, 1'b1, 1'b0, 32'h12, 0);
        wait_commit();
        check_output("perr_sticky", 64'(protocol_err), 64'd1);
        check_output("retired_7", retired_count, 64'd7);

        // Reset asserted during COMMIT of x3
        @(negedge clk);
        mem_wb_reg = '{alu_result: 32'h33, mem_read_data: 32'h0, rd: 5'd3, reg_write: 1'b1, mem_to_reg: 1'b0};
        mem_wb_push_done = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{rd: 5'd3, data: 32'h33, cyc: cyc + 1});
        @(negedge clk);
        mem_wb_push_done = 1'b0;
        @(posedge clk);
        #2;
        check_output("abort_in_commit", 64'(wb_commit), 64'd1);
        reset = 1'b0;
        #1;
        check_output("abort_commit_cleared", 64'(wb_commit), 64'd0);
        check_output("abort_retired", retired_count, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("abort_valid", 64'(wb_valid), 64'd1);
        check_output("abort_perr", 64'(protocol_err), 64'd0);
        read_reg("x3_abort", 5'd3, 32'h0);
        read_reg("x5_reset", 5'd5, 32'h0);
        check_output("retired_after_abort", retired_count, 64'd0);
        repeat (3) @(posedge clk);
        #2;
        check_output("queue_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
